// File: rtl/hazard_unit_if.sv
// Decode-side fields and hazard-control results exchanged between the
// pipeline top and the hazard unit.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [REG_W-1:0] id_dest;
  logic             br_taken;
  logic             stall;
  logic [2:0]       flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies decode fields, consumes hazard controls.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_mem_read,
           id_dest, br_taken,
    input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_mem_read,
           id_dest, br_taken,
    output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard control for the five-stage pipeline: tracks destinations held in
// ID/EX and EX/MEM, raises a one-bubble load-use stall, registers the EX
// forwarding selects, flushes wrong-path latches on a taken branch and
// counts stall/flush cycles with saturating counters.
module hazard_unit #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int BRANCH_STAGE = 3   // 2 = EX resolves, 3 = MEM resolves
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  bus
);

  // EX tracker mirrors ID/EX; the load flag is needed only here because
  // load-use is detected against the instruction directly ahead of ID.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             rw;
    logic             mr;
  } trk_ex_t;

  // MEM tracker mirrors EX/MEM; its result is already forwardable.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             rw;
  } trk_mem_t;

  localparam logic [2:0] FLUSH_VEC = (BRANCH_STAGE == 3) ? 3'b111 : 3'b011;

  trk_ex_t          tex_q, tex_d;
  trk_mem_t         tmem_q, tmem_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_c;
  logic [2:0]       flush_c;
  logic [1:0]       fwd_a_next, fwd_b_next;

  // A producer matches r only if it is live, writes, and is not $0.
  function automatic logic hit(input logic v, input logic rw,
                               input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] r);
    return v & rw & (dst != '0) & (dst == r);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Hazard detection, forwarding selection and next tracker/counter state.
  always_comb begin
    flush_c    = bus.br_taken ? FLUSH_VEC : 3'b000;
    // A taken branch squashes the would-be consumer, so it never stalls.
    stall_c    = bus.id_valid & ~bus.br_taken & tex_q.mr &
                 (hit(tex_q.v, tex_q.rw, tex_q.dst, bus.id_rs) |
                  (bus.id_uses_rt & hit(tex_q.v, tex_q.rw, tex_q.dst, bus.id_rt)));

    // Newer producer (EX) takes priority over the older one (MEM).
    fwd_a_next = 2'b00;
    if (hit(tex_q.v, tex_q.rw, tex_q.dst, bus.id_rs))
      fwd_a_next = 2'b10;
    else if (hit(tmem_q.v, tmem_q.rw, tmem_q.dst, bus.id_rs))
      fwd_a_next = 2'b01;

    fwd_b_next = 2'b00;
    if (bus.id_uses_rt) begin
      if (hit(tex_q.v, tex_q.rw, tex_q.dst, bus.id_rt))
        fwd_b_next = 2'b10;
      else if (hit(tmem_q.v, tmem_q.rw, tmem_q.dst, bus.id_rt))
        fwd_b_next = 2'b01;
    end

    // A bubble entering EX carries no forwarding.
    if (stall_c | flush_c[1] | ~bus.id_valid) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else begin
      fwd_a_d = fwd_a_next;
      fwd_b_d = fwd_b_next;
    end

    if (stall_c | flush_c[1])
      tex_d = '0;
    else
      tex_d = '{v: bus.id_valid, dst: bus.id_dest,
                rw: bus.id_reg_write, mr: bus.id_mem_read};

    if (flush_c[2])
      tmem_d = '0;
    else
      tmem_d = '{v: tex_q.v, dst: tex_q.dst, rw: tex_q.rw};

    stall_cnt_d = stall_c      ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = bus.br_taken ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // Tracker, forwarding-select and counter registers; reset clears validity.
  always_ff @(posedge clk) begin
    if (reset) begin
      tex_q.v     <= 1'b0;
      tmem_q.v    <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tex_q       <= tex_d;
      tmem_q      <= tmem_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flush     = flush_c;
  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a per-cycle vector table for the main
// scenarios plus hand sequences for counter saturation and reset mid-stall.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_W(5), .CNT_W(4))  bus3 ();
  hazard_unit_if #(.REG_W(5), .CNT_W(16)) bus2 ();

  hazard_unit #(.REG_W(5), .CNT_W(4), .BRANCH_STAGE(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3));
  hazard_unit #(.REG_W(5), .CNT_W(16), .BRANCH_STAGE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  assign bus2.id_valid     = bus3.id_valid;
  assign bus2.id_rs        = bus3.id_rs;
  assign bus2.id_rt        = bus3.id_rt;
  assign bus2.id_uses_rt   = bus3.id_uses_rt;
  assign bus2.id_reg_write = bus3.id_reg_write;
  assign bus2.id_mem_read  = bus3.id_mem_read;
  assign bus2.id_dest      = bus3.id_dest;
  assign bus2.br_taken     = bus3.br_taken;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       ut, rw, mr;
    logic [4:0] dst;
    logic       br;
    logic       e_stall;
    logic [2:0] e_fl3, e_fl2;
    logic [1:0] e_fa, e_fb;
    logic [3:0] e_scnt, e_fcnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic ut,
                              logic rw, logic mr, logic [4:0] dst, logic br,
                              logic st, logic [2:0] f3, logic [2:0] f2,
                              logic [1:0] fa, logic [1:0] fb,
                              logic [3:0] sc, logic [3:0] fc);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.ut = ut; t.rw = rw; t.mr = mr;
    t.dst = dst; t.br = br; t.e_stall = st; t.e_fl3 = f3; t.e_fl2 = f2;
    t.e_fa = fa; t.e_fb = fb; t.e_scnt = sc; t.e_fcnt = fc;
    return t;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic rw, input logic mr,
                       input logic [4:0] dst, input logic br);
    bus3.id_valid = v; bus3.id_rs = rs; bus3.id_rt = rt; bus3.id_uses_rt = ut;
    bus3.id_reg_write = rw; bus3.id_mem_read = mr; bus3.id_dest = dst;
    bus3.br_taken = br;
  endtask

  // Apply ID fields at the falling edge and settle the combinational outputs.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic rw, input logic mr,
                      input logic [4:0] dst, input logic br);
    @(negedge clk);
    drive(v, rs, rt, ut, rw, mr, dst, br);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                v  rs  rt ut rw mr dst br  st  fl3     fl2     fa     fb     sc fc
    vecs[0]  = mk(0,  0,  0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0); // idle
    vecs[1]  = mk(1,  1,  2, 1, 1, 0,  3, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0); // add $3
    vecs[2]  = mk(1,  3,  4, 1, 1, 0,  8, 0, 0, 3'b000, 3'b000, 2'b10, 2'b00, 0, 0); // sub rs=$3
    vecs[3]  = mk(0,  0,  0, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0);
    vecs[4]  = mk(1,  1,  2, 1, 1, 0,  3, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0); // add $3
    vecs[5]  = mk(1,  9, 10, 1, 1, 0, 11, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0); // unrelated
    vecs[6]  = mk(1,  3,  0, 0, 1, 0, 12, 0, 0, 3'b000, 3'b000, 2'b01, 2'b00, 0, 0); // reader $3
    vecs[7]  = mk(1,  2,  5, 0, 1, 1,  5, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0); // lw $5
    vecs[8]  = mk(1,  2,  5, 1, 1, 0, 13, 0, 1, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0); // add stalls
    vecs[9]  = mk(1,  2,  5, 1, 1, 0, 13, 0, 0, 3'b000, 3'b000, 2'b00, 2'b01, 1, 0); // add proceeds
    vecs[10] = mk(1,  1,  2, 1, 1, 0,  0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0); // add $0
    vecs[11] = mk(1,  0,  0, 1, 1, 0, 14, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0); // reader $0
    vecs[12] = mk(1,  1,  2, 1, 1, 0,  7, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0); // writer $7
    vecs[13] = mk(1,  1,  2, 1, 1, 0,  7, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0); // writer $7
    vecs[14] = mk(1,  7,  7, 1, 1, 0, 15, 0, 0, 3'b000, 3'b000, 2'b10, 2'b10, 1, 0); // reader $7
    vecs[15] = mk(1,  1,  2, 1, 1, 0,  9, 1, 0, 3'b111, 3'b011, 2'b00, 2'b00, 1, 1); // branch
    vecs[16] = mk(1, 15,  9, 1, 1, 0, 16, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 1); // trackers empty
    vecs[17] = mk(1,  1,  0, 0, 1, 1,  6, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 1); // lw $6
    vecs[18] = mk(1,  6,  2, 1, 1, 0, 17, 1, 0, 3'b111, 3'b011, 2'b00, 2'b00, 1, 2); // lu + branch
    vecs[19] = mk(1,  6,  2, 1, 0, 0, 18, 0, 0, 3'b000, 3'b000, 2'b00, 2'b00, 1, 2);

    // Reset with idle inputs, then check the cleared state.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_fwd_a", bus3.fwd_a, 0);
    chk("rst_fwd_b", bus3.fwd_b, 0);
    chk("rst_stall_cnt", bus3.stall_cnt, 0);
    chk("rst_flush_cnt", bus3.flush_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", bus3.stall, 0);
    chk("rst_flush", bus3.flush, 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].ut, vecs[i].rw,
           vecs[i].mr, vecs[i].dst, vecs[i].br);
      chk($sformatf("v%0d_stall", i), bus3.stall, vecs[i].e_stall);
      chk($sformatf("v%0d_flush_bs3", i), bus3.flush, vecs[i].e_fl3);
      chk($sformatf("v%0d_flush_bs2", i), bus2.flush, vecs[i].e_fl2);
      tick();
      chk($sformatf("v%0d_fwd_a", i), bus3.fwd_a, vecs[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), bus3.fwd_b, vecs[i].e_fb);
      chk($sformatf("v%0d_stall_cnt", i), bus3.stall_cnt, vecs[i].e_scnt);
      chk($sformatf("v%0d_flush_cnt", i), bus3.flush_cnt, vecs[i].e_fcnt);
    end

    // Repeated load-use pairs drive the 4-bit stall counter into saturation.
    for (int p = 1; p <= 20; p++) begin
      step(1, 2, 5, 0, 1, 1, 5, 0);
      tick();
      step(1, 2, 5, 1, 1, 0, 13, 0);
      chk($sformatf("sat%0d_stall", p), bus3.stall, 1);
      tick();
      chk($sformatf("sat%0d_stall_cnt", p), bus3.stall_cnt, (1 + p > 15) ? 15 : 1 + p);
    end

    // Reset while a load-use stall is pending.
    step(1, 2, 5, 0, 1, 1, 5, 0);
    tick();
    step(1, 2, 5, 1, 1, 0, 13, 0);
    chk("midrst_stall_before", bus3.stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_stall", bus3.stall, 0);
    chk("midrst_flush", bus3.flush, 0);
    chk("midrst_fwd_a", bus3.fwd_a, 0);
    chk("midrst_fwd_b", bus3.fwd_b, 0);
    chk("midrst_stall_cnt", bus3.stall_cnt, 0);
    chk("midrst_flush_cnt", bus3.flush_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
